lcd_ctrl_multi: RTL



---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_bus_driver.sv | 58 +++++
 rtl/lcd_ctrl_multi.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared command encodings and controller state type for the KS0108-class LCD controller.
package lcd_pkg;

    localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
    localparam logic [7:0] CMD_START_LINE = 8'hC0;
    localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
    localparam logic [7:0] CMD_SET_Y      = 8'h40;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ERASE,
        ST_IDLE,
        ST_REQ,
        ST_SETY,
        ST_DATA,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/lcd_bus_driver.sv
// LCD pin driver: toggles lcd_en every clock and registers one bus word per slot.
// Words load on the edge where lcd_en rises; slots without a command repeat display-on.
module lcd_bus_driver #(
    parameter int PANELS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    input  logic              cmd_di_i,
    input  logic [7:0]        cmd_data_i,
    input  logic [PANELS-1:0] cmd_cs_i,
    output logic              slot_go_o,
    output logic              lcd_en_o,
    output logic              lcd_di_o,
    output logic              lcd_rw_o,
    output logic [7:0]        lcd_data_o,
    output logic [PANELS-1:0] lcd_cs_o
);
    import lcd_pkg::*;

    logic              en_q;
    logic              di_q;
    logic              rw_q;
    logic [7:0]        data_q;
    logic [PANELS-1:0] cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            di_q   <= 1'b0;
            rw_q   <= 1'b0;
            data_q <= 8'h00;
            cs_q   <= '1;
        end else begin
            en_q <= ~en_q;
            if (!en_q) begin
                rw_q <= 1'b0;
                if (cmd_valid_i) begin
                    di_q   <= cmd_di_i;
                    data_q <= cmd_data_i;
                    cs_q   <= cmd_cs_i;
                end else begin
                    // filler slot keeps the last panel selection
                    di_q   <= 1'b0;
                    data_q <= CMD_DISP_ON;
                end
            end
        end
    end

    assign slot_go_o  = ~en_q;
    assign lcd_en_o   = en_q;
    assign lcd_di_o   = di_q;
    assign lcd_rw_o   = rw_q;
    assign lcd_data_o = data_q;
    assign lcd_cs_o   = cs_q;

endmodule

// File: rtl/lcd_ctrl_multi.sv
// Dual-panel graphic LCD controller: init, erase, then stream images from the page buffer
// one panel-half segment at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_INIT  | display-on then start-line, all panels selected
// ST_ERASE | per page: set page, set Y, COLS zero bytes
// ST_IDLE  | count slots while run is high
// ST_REQ   | request segment, wait for data_ack
// ST_SETY  | set Y address 0
// ST_DATA  | stream COLS bytes from the buffer
// ST_HOLD  | single-shot finished, wait for run low
module lcd_ctrl_multi #(
    parameter int NUM_IMAGES = 2,
    parameter int IMG_W      = 4,
    parameter int PAGES      = 8,
    parameter int COLS       = 64,
    parameter int PANELS     = 2,
    parameter int IDLE_SLOTS = 10000,
    parameter int LOOP       = 1,
    localparam int PANEL_W   = (PANELS > 1) ? $clog2(PANELS) : 1,
    localparam int ADDR_W    = IMG_W + 3 + PANEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic              data_ack_i,
    input  logic [7:0]        data_i,
    output logic              data_request_o,
    output logic              data_pop_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              lcd_di_o,
    output logic              lcd_rw_o,
    output logic              lcd_en_o,
    output logic              lcd_rst_o,
    output logic [PANELS-1:0] lcd_cs_o,
    output logic [7:0]        lcd_data_o,
    output logic              frame_done_o,
    output logic              busy_o
);
    import lcd_pkg::*;

    localparam int IDLE_W = (IDLE_SLOTS > 1) ? $clog2(IDLE_SLOTS) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_LOAD  = IDLE_W'(IDLE_SLOTS - 1);
    localparam logic [6:0]         COL_LAST   = 7'(COLS - 1);
    localparam logic [6:0]         ERASE_LAST = 7'(COLS + 1);
    localparam logic [2:0]         PAGE_LAST  = 3'(PAGES - 1);
    localparam logic [PANEL_W-1:0] PANEL_LAST = PANEL_W'(PANELS - 1);
    localparam logic [IMG_W-1:0]   IMG_LAST   = IMG_W'(NUM_IMAGES - 1);

    state_e              state_q, state_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [2:0]          page_q, page_d;
    logic [PANEL_W-1:0]  panel_q, panel_d;
    logic [IMG_W-1:0]    img_q, img_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                pop_q, pop_d;
    logic                frame_q, frame_d;

    logic                slot_go;
    logic                cmd_valid;
    logic                cmd_di;
    logic [7:0]          cmd_data;
    logic [PANELS-1:0]   cmd_cs;
    logic [PANELS-1:0]   cs_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            page_q  <= '0;
            panel_q <= '0;
            img_q   <= '0;
            idle_q  <= IDLE_LOAD;
            pop_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            page_q  <= page_d;
            panel_q <= panel_d;
            img_q   <= img_d;
            idle_q  <= idle_d;
            pop_q   <= pop_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        page_d    = page_q;
        panel_d   = panel_q;
        img_d     = img_q;
        idle_d    = idle_q;
        pop_d     = 1'b0;
        frame_d   = 1'b0;
        cmd_valid = 1'b0;
        cmd_di    = 1'b0;
        cmd_data  = CMD_DISP_ON;
        cmd_cs    = '1;
        cs_hot    = '0;
        cs_hot[panel_q] = 1'b1;

        if (slot_go) begin
            case (state_q)
                ST_INIT: begin
                    cmd_valid = 1'b1;
                    if (cnt_q == 7'd0) begin
                        cnt_d = 7'd1;
                    end else begin
                        cmd_data = CMD_START_LINE;
                        cnt_d    = '0;
                        page_d   = '0;
                        state_d  = ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    cmd_valid = 1'b1;
                    if (cnt_q == 7'd0) begin
                        cmd_data = CMD_SET_PAGE | {5'b0, page_q};
                    end else if (cnt_q == 7'd1) begin
                        cmd_data = CMD_SET_Y;
                    end else begin
                        cmd_di   = 1'b1;
                        cmd_data = 8'h00;
                    end
                    if (cnt_q == ERASE_LAST) begin
                        cnt_d = '0;
                        if (page_q == PAGE_LAST) begin
                            page_d  = '0;
                            img_d   = '0;
                            idle_d  = IDLE_LOAD;
                            state_d = ST_IDLE;
                        end else begin
                            page_d = page_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (run_i) begin
                        if (idle_q == '0) begin
                            idle_d  = IDLE_LOAD;
                            page_d  = '0;
                            panel_d = '0;
                            state_d = ST_REQ;
                        end else begin
                            idle_d = idle_q - IDLE_W'(1);
                        end
                    end
                end
                ST_REQ: begin
                    if (data_ack_i) begin
                        cmd_valid = 1'b1;
                        cmd_data  = CMD_SET_PAGE | {5'b0, page_q};
                        cmd_cs    = cs_hot;
                        state_d   = ST_SETY;
                    end
                end
                ST_SETY: begin
                    cmd_valid = 1'b1;
                    cmd_data  = CMD_SET_Y;
                    cmd_cs    = cs_hot;
                    cnt_d     = '0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    cmd_valid = 1'b1;
                    cmd_di    = 1'b1;
                    cmd_data  = data_i;
                    cmd_cs    = cs_hot;
                    pop_d     = 1'b1;
                    if (cnt_q == COL_LAST) begin
                        cnt_d = '0;
                        // panel is the inner loop so both halves of a page go out together
                        if (panel_q != PANEL_LAST) begin
                            panel_d = panel_q + PANEL_W'(1);
                            state_d = ST_REQ;
                        end else if (page_q != PAGE_LAST) begin
                            panel_d = '0;
                            page_d  = page_q + 3'd1;
                            state_d = ST_REQ;
                        end else begin
                            panel_d = '0;
                            page_d  = '0;
                            frame_d = 1'b1;
                            if (img_q == IMG_LAST) begin
                                if (LOOP != 0) begin
                                    img_d   = '0;
                                    state_d = ST_IDLE;
                                end else begin
                                    img_d   = img_q + IMG_W'(1);
                                    state_d = ST_HOLD;
                                end
                            end else begin
                                img_d   = img_q + IMG_W'(1);
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                ST_HOLD: begin
                    if (!run_i) begin
                        img_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    lcd_bus_driver #(
        .PANELS (PANELS)
    ) u_bus (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_di_i    (cmd_di),
        .cmd_data_i  (cmd_data),
        .cmd_cs_i    (cmd_cs),
        .slot_go_o   (slot_go),
        .lcd_en_o    (lcd_en_o),
        .lcd_di_o    (lcd_di_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_data_o  (lcd_data_o),
        .lcd_cs_o    (lcd_cs_o)
    );

    assign addr_o         = {img_q, page_q, panel_q};
    assign data_request_o = (state_q == ST_REQ);
    assign data_pop_o     = pop_q;
    assign frame_done_o   = frame_q;
    assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    assign lcd_rst_o      = rst_n;

endmodule
